pll_reset_sequencer: RTL and testbench

- Controls bring-up and recovery of the 50->140 MHz system PLL.
- Runs on the free-running 50 MHz reference clock.
- Drives the PLL reset, qualifies the PLL locked flag, and releases the system reset only after lock has been stable for a programmed time.
- Retries the PLL on lock timeout, re-sequences on loss of lock, and latches a fault after repeated failures.

---
 rtl/pll_reset_sequencer_if.sv | 22 ++
 rtl/pll_reset_sequencer.sv | 130 +++++++++++++
 tb/tb_pll_reset_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_if.sv
// Handshake bundle between the PLL reset sequencer and its environment.
// The sequencer takes the slave modport; the stimulus side takes master.
interface pll_reset_sequencer_if;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_reset_n;
  logic       ready;
  logic       fault;
  logic [7:0] lol_count;
  logic [2:0] state;

  modport slave (
    input  pll_locked, restart,
    output pll_rst, sys_reset_n, ready, fault, lol_count, state
  );

  modport master (
    output pll_locked, restart,
    input  pll_rst, sys_reset_n, ready, fault, lol_count, state
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up/recovery sequencer on the free-running reference clock.
// Holds the system in reset until lock has been stable, retries on timeout, latches FAULT.
module pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int MAX_RETRIES         = 3,
  parameter int CNT_W               = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  pll_reset_sequencer_if.slave  bus
);

  localparam int RTY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STB_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RTY_LAST   = RTY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [7:0]       lol_q, lol_d;
  logic [1:0]       sync_q;
  logic             locked_s;

  // pll_locked comes from the PLL's own lock detector, asynchronous to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b00;
    else          sync_q <= {sync_q[0], bus.pll_locked};
  end

  assign locked_s = sync_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= PLL_RST;
      cnt_q   <= '0;
      retry_q <= '0;
      lol_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      lol_q   <= lol_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lol_d   = lol_q;
    if (bus.restart) begin
      state_d = PLL_RST;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        PLL_RST: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == RST_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        // Lock is checked before the timeout so a coincident lock wins.
        WAIT_LOCK: begin
          if (locked_s) begin
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_d = '0;
            if (retry_q == RTY_LAST) begin
              state_d = FAULT;
            end else begin
              state_d = PLL_RST;
              retry_d = retry_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STB_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_d = PLL_RST;
            cnt_d   = '0;
            retry_d = '0;
            if (lol_q != 8'hFF) lol_d = lol_q + 8'd1;
          end
        end
        FAULT: ;
        default: begin
          state_d = PLL_RST;
          cnt_d   = '0;
          retry_d = '0;
        end
      endcase
    end
  end

  assign bus.pll_rst     = (state_q == PLL_RST) || (state_q == FAULT);
  assign bus.sys_reset_n = (state_q == RUN);
  assign bus.ready       = (state_q == RUN);
  assign bus.fault       = (state_q == FAULT);
  assign bus.lol_count   = lol_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: per-cycle comparison against a phase/elapsed-time
// model, plus directed scenarios with literal cycle counts.
module tb_pll_reset_sequencer;
  localparam int RP = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int MR = 2;

  localparam int S_STATE = 0, S_READY = 1, S_FAULT = 2, S_PLLRST = 3, S_SYSN = 4;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  pll_reset_sequencer_if bus ();

  pll_reset_sequencer #(
    .RST_PULSE_CYCLES(RP), .LOCK_TIMEOUT_CYCLES(TO), .LOCK_STABLE_CYCLES(ST),
    .MAX_RETRIES(MR), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: phase number (0 pulse, 1 wait, 2 stable, 3 run, 4 fault),
  // cycles spent in the phase, retries used, and loss-of-lock tally.
  int m_ph, m_t, m_tries, m_lol;
  bit h0, h1;

  task automatic model_reset();
    m_ph = 0; m_t = 0; m_tries = 0; m_lol = 0; h0 = 0; h1 = 0;
  endtask

  task automatic model_step();
    bit ls;
    ls = h1; h1 = h0; h0 = bus.pll_locked;
    if (bus.restart) begin
      m_ph = 0; m_t = 0; m_tries = 0;
    end else begin
      case (m_ph)
        0: begin m_t++; if (m_t == RP) begin m_ph = 1; m_t = 0; end end
        1: if (ls) begin m_ph = 2; m_t = 0; end
           else begin
             m_t++;
             if (m_t == TO) begin
               m_t = 0;
               if (m_tries == MR) m_ph = 4;
               else begin m_tries++; m_ph = 0; end
             end
           end
        2: if (!ls) begin m_ph = 1; m_t = 0; end
           else begin m_t++; if (m_t == ST) begin m_ph = 3; m_t = 0; end end
        3: if (!ls) begin
             m_ph = 0; m_t = 0; m_tries = 0;
             if (m_lol < 255) m_lol++;
           end
        default: ;
      endcase
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_pll_rst", int'(bus.pll_rst), int'(m_ph == 0 || m_ph == 4));
      chk("cyc_sys_reset_n", int'(bus.sys_reset_n), int'(m_ph == 3));
      chk("cyc_ready", int'(bus.ready), int'(m_ph == 3));
      chk("cyc_fault", int'(bus.fault), int'(m_ph == 4));
      chk("cyc_state", int'(bus.state), m_ph);
      chk("cyc_lol_count", int'(bus.lol_count), m_lol);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int get_sig(input int which);
    case (which)
      S_STATE:  return int'(bus.state);
      S_READY:  return int'(bus.ready);
      S_FAULT:  return int'(bus.fault);
      S_PLLRST: return int'(bus.pll_rst);
      default:  return int'(bus.sys_reset_n);
    endcase
  endfunction

  // Ticks until the selected output equals val; n = edges taken.
  task automatic wait_sig(input string nm, input int which, input int val,
                          input int budget, output int n);
    n = 0;
    while (get_sig(which) != val && n < budget) begin
      tick();
      n++;
    end
    if (get_sig(which) != val) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles, got %0d expected %0d",
               nm, n, get_sig(which), val);
    end
  endtask

  initial begin
    int n, n2, pulses, bad, cycles;
    bit prev;
    reset_n = 1'b0;
    bus.pll_locked = 1'b0;
    bus.restart = 1'b0;
    repeat (3) tick();
    chk("reset_pll_rst", int'(bus.pll_rst), 1);
    chk("reset_sys_reset_n", int'(bus.sys_reset_n), 0);
    chk("reset_state", int'(bus.state), 0);

    // 1. Bring-up
    reset_n = 1'b1;
    wait_sig("bringup_rst_fall", S_PLLRST, 0, 100, n);
    chk("bringup_pll_rst_len", n, 4);
    repeat (4) tick();
    bus.pll_locked = 1'b1;
    wait_sig("bringup_release", S_SYSN, 1, 100, n);
    chk("bringup_release_edges", n, 11);
    chk("bringup_ready", int'(bus.ready), 1);
    chk("bringup_state", int'(bus.state), 3);

    // 2. Lock glitch during STABLE
    bus.restart = 1'b1; bus.pll_locked = 1'b0;
    tick();
    bus.restart = 1'b0;
    wait_sig("glitch_wait", S_STATE, 1, 50, n);
    repeat (2) tick();
    bus.pll_locked = 1'b1;
    wait_sig("glitch_stable", S_STATE, 2, 50, n);
    chk("glitch_to_stable_edges", n, 3);
    repeat (2) tick();
    bus.pll_locked = 1'b0;
    n = 0; bad = 0;
    while (bus.state != 3'd1 && n < 50) begin
      tick(); n++;
      if (bus.sys_reset_n) bad++;
    end
    chk("glitch_back_to_wait", int'(bus.state), 1);
    chk("glitch_back_edges", n, 3);
    chk("glitch_no_release", bad, 0);
    bus.pll_locked = 1'b1;
    wait_sig("glitch_relock", S_SYSN, 1, 100, n);
    chk("glitch_relock_edges", n, 11);

    // 3. Timeout to FAULT
    bus.pll_locked = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n = 0; pulses = 0; prev = 1'b1;
    while (!bus.fault && n < 500) begin
      tick(); n++;
      if (prev && !bus.pll_rst) pulses++;
      prev = bus.pll_rst;
    end
    chk("fault_cycles", n, 72);
    chk("fault_pulses", pulses, 3);
    chk("fault_pll_rst", int'(bus.pll_rst), 1);
    repeat (30) tick();
    chk("fault_held", int'(bus.state), 4);

    // 4. Loss of lock in RUN
    bus.restart = 1'b1; bus.pll_locked = 1'b1;
    tick();
    bus.restart = 1'b0;
    wait_sig("lol_run", S_READY, 1, 200, n);
    bus.pll_locked = 1'b0;
    wait_sig("lol_drop", S_SYSN, 0, 20, n);
    chk("lol_drop_edges", n, 3);
    chk("lol_pll_rst", int'(bus.pll_rst), 1);
    chk("lol_count_1", int'(bus.lol_count), 1);
    for (int i = 0; i < 259; i++) begin
      // Randomised lock delay inside the timeout window.
      repeat ($urandom_range(0, 8)) tick();
      bus.pll_locked = 1'b1;
      wait_sig("lol_rep_run", S_READY, 1, 200, n);
      repeat ($urandom_range(0, 3)) tick();
      bus.pll_locked = 1'b0;
      wait_sig("lol_rep_drop", S_STATE, 0, 20, n);
    end
    chk("lol_count_sat", int'(bus.lol_count), 255);

    // 5. Restart out of FAULT, and restart coincident with a timeout
    wait_sig("restart_fault", S_FAULT, 1, 300, n);
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    chk("restart_fault_clr", int'(bus.fault), 0);
    chk("restart_state", int'(bus.state), 0);
    wait_sig("restart_pulse", S_PLLRST, 0, 50, n);
    chk("restart_pulse_len", n, 4);
    wait_sig("restart_budget", S_FAULT, 1, 300, n2);
    chk("restart_budget_cycles", n + n2, 72);
    chk("restart_lol_kept", int'(bus.lol_count), 255);
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    repeat (47) tick();
    chk("restart_to_pre", int'(bus.state), 1);
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    chk("restart_to_state", int'(bus.state), 0);
    wait_sig("restart_to_budget", S_FAULT, 1, 300, n);
    chk("restart_to_budget_cycles", n, 72);

    // 6. Async reset mid-STABLE
    bus.restart = 1'b1; bus.pll_locked = 1'b1;
    tick();
    bus.restart = 1'b0;
    wait_sig("async_stable", S_STATE, 2, 50, n);
    repeat (2) tick();
    #2 reset_n = 1'b0;
    #1;
    cycles = 0;
    chk("async_pll_rst", int'(bus.pll_rst), 1);
    chk("async_sys_reset_n", int'(bus.sys_reset_n), 0);
    chk("async_ready", int'(bus.ready), 0);
    chk("async_fault", int'(bus.fault), 0);
    chk("async_state", int'(bus.state), 0);
    chk("async_lol", int'(bus.lol_count), 0);
    tick();
    reset_n = 1'b1;
    wait_sig("async_rebringup", S_READY, 1, 100, n);
    chk("async_rebringup_state", int'(bus.state), 3 + cycles);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
